// File: rtl/pcie_tx_arbiter.sv
// pcie_tx_arbiter
//   Transmit-side source for the transaction path. Two client queues accept
//   payload words, each word is tagged with its VC bit and destination bit,
//   and a round-robin arbiter merges both queues into a single registered
//   word stream feeding the main FIFO push interface. Honors the main FIFO
//   pause backpressure and reports queue status and link state.
//
// Ports
//   clk, reset            : clock (rising edge), asynchronous active-high reset
//   data_in0 / data_in1   : payload (BITNUMBER-2 bits) for destination 0 / 1
//   vc_in0 / vc_in1       : VC select accompanying each payload
//   push0 / push1         : write strobe for queue 0 / 1
//   pause                 : main FIFO backpressure; no word issued while high
//   data_out / push_out   : tagged word and push strobe to the main FIFO
//   full0/1, empty0/1     : queue occupancy status
//   wr_error0/1           : one-cycle pulse when a push to a full queue drops
//   state                 : arbiter state (IDLE=0, ACTIVE=1, PAUSED=2)
//   tx_count              : count of issued words, wraps at 256
module pcie_tx_arbiter #(
  parameter int BITNUMBER  = 6,
  parameter int DEPTH_BITS = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [BITNUMBER-3:0] data_in0,
  input  logic [BITNUMBER-3:0] data_in1,
  input  logic                 vc_in0,
  input  logic                 vc_in1,
  input  logic                 push0,
  input  logic                 push1,
  input  logic                 pause,
  output logic [BITNUMBER-1:0] data_out,
  output logic                 push_out,
  output logic                 full0,
  output logic                 full1,
  output logic                 empty0,
  output logic                 empty1,
  output logic                 wr_error0,
  output logic                 wr_error1,
  output logic [1:0]           state,
  output logic [7:0]           tx_count
);

  localparam int unsigned         DEPTH    = 2 ** DEPTH_BITS;
  localparam int                  EW       = BITNUMBER - 1;  // vc + payload
  localparam int                  PW       = BITNUMBER - 2;  // payload
  localparam logic [DEPTH_BITS:0] CNT_FULL = (DEPTH_BITS + 1)'(DEPTH);
  localparam logic [DEPTH_BITS:0] ONE      = (DEPTH_BITS + 1)'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    PAUSED = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [1:0]                   w_push;
  logic [1:0][EW-1:0]           w_din;
  logic [1:0]                   w_full;
  logic [1:0]                   w_empty;
  logic [1:0]                   w_wr_ok;
  logic [1:0]                   w_pop;
  logic [1:0]                   w_err;
  logic [1:0][EW-1:0]           w_head;
  logic [1:0][DEPTH_BITS:0]     w_left;
  logic                         w_sel;
  logic                         w_any_pop;
  logic                         w_any_ne;
  logic                         w_drained;

  logic                 r_last_grant;
  logic                 r_push_out;
  logic [BITNUMBER-1:0] r_data_out;
  logic [7:0]           r_tx_count;

  assign w_push   = {push1, push0};
  assign w_din[0] = {vc_in0, data_in0};
  assign w_din[1] = {vc_in1, data_in1};
  // Full is sampled before the edge, so a push to a full queue is dropped
  // even when the same queue pops on that edge.
  assign w_wr_ok  = w_push & ~w_full;

  for (genvar g = 0; g < 2; g++) begin : g_queue
    logic [EW-1:0]       r_mem [DEPTH];
    logic [DEPTH_BITS:0] r_wptr;
    logic [DEPTH_BITS:0] r_rptr;
    logic [DEPTH_BITS:0] r_cnt;
    logic                r_wr_err;

    // Storage carries no reset; occupancy and pointers define validity.
    always_ff @(posedge clk) begin
      if (w_wr_ok[g]) begin
        r_mem[r_wptr[DEPTH_BITS-1:0]] <= w_din[g];
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_wptr   <= '0;
        r_rptr   <= '0;
        r_cnt    <= '0;
        r_wr_err <= 1'b0;
      end else begin
        r_wr_err <= w_push[g] & w_full[g];
        if (w_wr_ok[g]) r_wptr <= r_wptr + ONE;
        if (w_pop[g])   r_rptr <= r_rptr + ONE;
        case ({w_wr_ok[g], w_pop[g]})
          2'b10:   r_cnt <= r_cnt + ONE;
          2'b01:   r_cnt <= r_cnt - ONE;
          default: r_cnt <= r_cnt;
        endcase
      end
    end

    assign w_full[g]  = (r_cnt == CNT_FULL);
    assign w_empty[g] = (r_cnt == '0);
    assign w_head[g]  = r_mem[r_rptr[DEPTH_BITS-1:0]];
    assign w_left[g]  = r_cnt - (DEPTH_BITS + 1)'(w_pop[g]);
    assign w_err[g]   = r_wr_err;
  end

  // Round-robin grant: on a tie the queue not granted last wins.
  always_comb begin
    w_pop = '0;
    if (!pause) begin
      if (!w_empty[0] && !w_empty[1]) begin
        if (r_last_grant) w_pop[0] = 1'b1;
        else              w_pop[1] = 1'b1;
      end else if (!w_empty[0]) begin
        w_pop[0] = 1'b1;
      end else if (!w_empty[1]) begin
        w_pop[1] = 1'b1;
      end
    end
  end

  assign w_sel     = w_pop[1];
  assign w_any_pop = |w_pop;
  assign w_any_ne  = ~(&w_empty);
  assign w_drained = (w_left[0] == '0) && (w_left[1] == '0) && !push0 && !push1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_data_out   <= '0;
      r_push_out   <= 1'b0;
      r_last_grant <= 1'b1;
      r_tx_count   <= '0;
    end else begin
      r_push_out <= w_any_pop;
      r_tx_count <= r_tx_count + 8'(w_any_pop);
      if (w_any_pop) begin
        r_data_out   <= {w_head[w_sel][EW-1], w_sel, w_head[w_sel][PW-1:0]};
        r_last_grant <= w_sel;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_any_ne) w_state_nxt = pause ? PAUSED : ACTIVE;
      end
      ACTIVE: begin
        if (pause)          w_state_nxt = PAUSED;
        else if (w_drained) w_state_nxt = IDLE;
      end
      PAUSED: begin
        if (!pause) w_state_nxt = w_any_ne ? ACTIVE : IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign data_out  = r_data_out;
  assign push_out  = r_push_out;
  assign full0     = w_full[0];
  assign full1     = w_full[1];
  assign empty0    = w_empty[0];
  assign empty1    = w_empty[1];
  assign wr_error0 = w_err[0];
  assign wr_error1 = w_err[1];
  assign state     = r_state;
  assign tx_count  = r_tx_count;

endmodule

// File: tb/tb_pcie_tx_arbiter.sv
module tb_pcie_tx_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] data_in0, data_in1;
  logic       vc_in0, vc_in1, push0, push1, pause;
  logic [5:0] data_out;
  logic       push_out, full0, full1, empty0, empty1, wr_error0, wr_error1;
  logic [1:0] state;
  logic [7:0] tx_count;

  int tests = 0;
  int fails = 0;

  pcie_tx_arbiter #(.BITNUMBER(6), .DEPTH_BITS(2)) dut (
    .clk(clk), .reset(reset),
    .data_in0(data_in0), .data_in1(data_in1),
    .vc_in0(vc_in0), .vc_in1(vc_in1),
    .push0(push0), .push1(push1), .pause(pause),
    .data_out(data_out), .push_out(push_out),
    .full0(full0), .full1(full1), .empty0(empty0), .empty1(empty1),
    .wr_error0(wr_error0), .wr_error1(wr_error1),
    .state(state), .tx_count(tx_count)
  );

  always #5 clk = ~clk;

  // Reference model: two FIFOs of {vc,payload}, a last-grant bit and the
  // expected registered outputs.
  logic [4:0] q0[$];
  logic [4:0] q1[$];
  logic [5:0] issued[$];
  bit         m_last;
  logic [5:0] m_dout;
  bit         m_pout, m_err0, m_err1;
  logic [7:0] m_cnt;
  logic [1:0] m_state;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q0.delete(); q1.delete();
    m_last = 1'b1; m_dout = '0; m_pout = 1'b0;
    m_err0 = 1'b0; m_err1 = 1'b0; m_cnt = '0; m_state = 2'd0;
  endtask

  task automatic model_edge(input bit p0, input logic [3:0] d0, input bit v0,
                            input bit p1, input logic [3:0] d1, input bit v1,
                            input bit pz);
    int s0 = q0.size();
    int s1 = q1.size();
    bit g0 = 1'b0, g1 = 1'b0;
    bit ne = (s0 != 0) || (s1 != 0);
    logic [4:0] w;
    logic [1:0] ns = m_state;
    if (!pz) begin
      if (s0 != 0 && s1 != 0) begin
        if (m_last) g0 = 1'b1; else g1 = 1'b1;
      end else if (s0 != 0) g0 = 1'b1;
      else if (s1 != 0) g1 = 1'b1;
    end
    case (m_state)
      2'd0: if (ne) ns = pz ? 2'd2 : 2'd1;
      2'd1: begin
        if (pz) ns = 2'd2;
        else if ((s0 - int'(g0)) == 0 && (s1 - int'(g1)) == 0 && !p0 && !p1) ns = 2'd0;
      end
      default: if (!pz) ns = ne ? 2'd1 : 2'd0;
    endcase
    m_state = ns;
    m_err0 = p0 && (s0 == 4);
    m_err1 = p1 && (s1 == 4);
    if (g0) begin w = q0.pop_front(); m_dout = {w[4], 1'b0, w[3:0]}; m_last = 1'b0; end
    if (g1) begin w = q1.pop_front(); m_dout = {w[4], 1'b1, w[3:0]}; m_last = 1'b1; end
    m_pout = g0 | g1;
    if (m_pout) m_cnt = m_cnt + 8'd1;
    if (p0 && s0 != 4) q0.push_back({v0, d0});
    if (p1 && s1 != 4) q1.push_back({v1, d1});
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".data_out"},  32'(data_out),  32'(m_dout));
    chk({tag, ".push_out"},  32'(push_out),  32'(m_pout));
    chk({tag, ".full0"},     32'(full0),     32'(q0.size() == 4));
    chk({tag, ".full1"},     32'(full1),     32'(q1.size() == 4));
    chk({tag, ".empty0"},    32'(empty0),    32'(q0.size() == 0));
    chk({tag, ".empty1"},    32'(empty1),    32'(q1.size() == 0));
    chk({tag, ".wr_error0"}, 32'(wr_error0), 32'(m_err0));
    chk({tag, ".wr_error1"}, 32'(wr_error1), 32'(m_err1));
    chk({tag, ".state"},     32'(state),     32'(m_state));
    chk({tag, ".tx_count"},  32'(tx_count),  32'(m_cnt));
  endtask

  task automatic step(input string tag,
                      input bit p0, input logic [3:0] d0, input bit v0,
                      input bit p1, input logic [3:0] d1, input bit v1,
                      input bit pz);
    push0 = p0; data_in0 = d0; vc_in0 = v0;
    push1 = p1; data_in1 = d1; vc_in1 = v1;
    pause = pz;
    @(posedge clk);
    model_edge(p0, d0, v0, p1, d1, v1, pz);
    #1;
    check_all(tag);
    if (push_out) issued.push_back(data_out);
  endtask

  task automatic idle(input string tag, input int n);
    repeat (n) step(tag, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
  endtask

  // Reset raised between edges; outputs must clear before the next edge.
  task automatic do_reset(input string tag);
    push0 = 1'b0; push1 = 1'b0;
    #3 reset = 1'b1;
    #1;
    model_reset();
    check_all({tag, ".async"});
    @(posedge clk);
    #1;
    check_all({tag, ".held"});
    reset = 1'b0;
  endtask

  initial begin
    int exp_rr[6] = '{0, 5, 1, 6, 2, 7};
    int exp_pm[4] = '{8, 9, 10, 11};

    reset = 1'b1; pause = 1'b0;
    push0 = 1'b0; push1 = 1'b0; data_in0 = '0; data_in1 = '0; vc_in0 = 1'b0; vc_in1 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    check_all("por");
    reset = 1'b0;

    // Reset mid-stream with three words queued
    step("rstq", 1'b1, 4'h1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1);
    step("rstq", 1'b1, 4'h2, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1);
    step("rstq", 1'b1, 4'h3, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1);
    do_reset("rst");
    issued.delete();
    idle("rst_after", 3);
    chk("rst_no_issue", 32'(issued.size()), 32'd0);

    // Round-robin from a fresh reset: queue 0 wins the first tie
    step("rr", 1'b1, 4'd0, 1'b0, 1'b1, 4'd5, 1'b0, 1'b0);
    step("rr", 1'b1, 4'd1, 1'b0, 1'b1, 4'd6, 1'b0, 1'b0);
    step("rr", 1'b1, 4'd2, 1'b0, 1'b1, 4'd7, 1'b0, 1'b0);
    idle("rr", 6);
    chk("rr_count", 32'(issued.size()), 32'd6);
    for (int i = 0; i < 6 && i < issued.size(); i++) begin
      chk("rr_payload", 32'(issued[i][3:0]), 32'(exp_rr[i]));
      chk("rr_dest",    32'(issued[i][4]),   32'(i % 2));
    end
    chk("rr_tx_count", 32'(tx_count), 32'd6);

    // Single word: payload A, vc 1, two-cycle latency
    step("single", 1'b1, 4'hA, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
    chk("single_lat1", 32'(push_out), 32'd0);
    idle("single", 1);
    chk("single_push", 32'(push_out), 32'd1);
    chk("single_word", 32'(data_out), 32'b10_1010);
    idle("single", 2);
    chk("single_state", 32'(state), 32'd0);
    chk("single_tx", 32'(tx_count), 32'd7);

    // Overflow while paused
    for (int i = 0; i < 5; i++) begin
      step("ovf", 1'b1, 4'(i), 1'b0, 1'b0, 4'h0, 1'b0, 1'b1);
      if (i == 3) chk("ovf_full", 32'(full0), 32'd1);
    end
    chk("ovf_err", 32'(wr_error0), 32'd1);
    step("ovf", 1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1);
    chk("ovf_err_pulse", 32'(wr_error0), 32'd0);
    issued.delete();
    idle("ovf_drain", 6);
    chk("ovf_issued", 32'(issued.size()), 32'd4);

    // Pause mid-stream after the second issue
    issued.delete();
    step("pm", 1'b0, 4'h0, 1'b0, 1'b1, 4'd8,  1'b0, 1'b0);
    step("pm", 1'b0, 4'h0, 1'b0, 1'b1, 4'd9,  1'b1, 1'b0);
    step("pm", 1'b0, 4'h0, 1'b0, 1'b1, 4'd10, 1'b0, 1'b0);
    step("pm", 1'b0, 4'h0, 1'b0, 1'b1, 4'd11, 1'b1, 1'b1);
    chk("pm_state", 32'(state), 32'd2);
    chk("pm_nopush", 32'(push_out), 32'd0);
    step("pm", 1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1);
    chk("pm_hold", 32'(push_out), 32'd0);
    idle("pm_release", 5);
    chk("pm_count", 32'(issued.size()), 32'd4);
    for (int i = 0; i < 4 && i < issued.size(); i++)
      chk("pm_order", 32'(issued[i][3:0]), 32'(exp_pm[i]));

    // Counter wrap: 257 issued words from reset
    do_reset("wrap_rst");
    repeat (257) step("wrap", 1'b1, 4'($urandom_range(15)), 1'($urandom_range(1)),
                      1'b0, 4'h0, 1'b0, 1'b0);
    idle("wrap", 3);
    chk("wrap_tx", 32'(tx_count), 32'd1);

    // Push and pop on the same edge of a full queue: push dropped
    for (int i = 0; i < 4; i++) step("fpp", 1'b1, 4'(i + 3), 1'b0, 1'b0, 4'h0, 1'b0, 1'b1);
    step("fpp", 1'b1, 4'hF, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
    chk("fpp_err", 32'(wr_error0), 32'd1);
    chk("fpp_pop", 32'(push_out), 32'd1);
    idle("fpp", 6);

    // Randomized traffic against the model, with occasional reset
    for (int n = 0; n < 500; n++) begin
      if ($urandom_range(99) == 0) do_reset("rnd_rst");
      else step("rnd",
                1'($urandom_range(1)), 4'($urandom_range(15)), 1'($urandom_range(1)),
                1'($urandom_range(1)), 4'($urandom_range(15)), 1'($urandom_range(1)),
                $urandom_range(3) == 0);
    end
    idle("rnd_drain", 10);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pcie_tx_arbiter.md
# pcie_tx_arbiter

Transmit-side source for the PCIe-style transaction path. Two client queues (destination 0 and destination 1) accept payload words, and the block tags each word with its VC and destination bits. A round-robin arbiter merges the two queues into the single word stream that feeds the path's main FIFO push interface. The block honors the main FIFO's `pause` backpressure and reports queue status and link state.

## Interface
Parameters:
- `BITNUMBER`, 6: width of the transmitted word; payload is `BITNUMBER-2` bits.
- `DEPTH_BITS`, 2: log2 of each internal client queue depth (default depth 4).

Ports:
- `clk`, in, 1: single clock, rising edge.
- `reset`, in, 1: asynchronous, active-high.
- `data_in0`, in, `BITNUMBER-2`: payload for destination 0.
- `data_in1`, in, `BITNUMBER-2`: payload for destination 1.
- `vc_in0`, in, 1: VC select for `data_in0` (0 = VC0, 1 = VC1).
- `vc_in1`, in, 1: VC select for `data_in1`.
- `push0`, in, 1: write `data_in0`/`vc_in0` into queue 0.
- `push1`, in, 1: write `data_in1`/`vc_in1` into queue 1.
- `pause`, in, 1: backpressure from the main FIFO; while high, no word is issued.
- `data_out`, out, `BITNUMBER`: tagged word for the main FIFO data input.
- `push_out`, out, 1: main FIFO push.
- `full0`, out, 1: queue 0 full status.
- `full1`, out, 1: queue 1 full status.
- `empty0`, out, 1: queue 0 empty status.
- `empty1`, out, 1: queue 1 empty status.
- `wr_error0`, out, 1: one-cycle pulse when a push to queue 0 is dropped.
- `wr_error1`, out, 1: one-cycle pulse when a push to queue 1 is dropped.
- `state`, out, 2: arbiter state; IDLE=0, ACTIVE=1, PAUSED=2.
- `tx_count`, out, 8: count of words issued; wraps 255 -> 0.

## Operation
- Each client queue is a circular buffer with `2**DEPTH_BITS` entries.
  - Entries are `BITNUMBER-1` bits wide: the vc bit plus the payload.
  - Write pointer, read pointer and occupancy counter are each `DEPTH_BITS+1` bits wide.
- Full and empty are derived from occupancy.
- Push to a full queue (full sampled before the edge):
  - The word is dropped and the pointers are unchanged.
  - `wr_error` pulses high for exactly the next cycle.
  - This holds even if that queue is popped in the same cycle.
- Push to a non-full queue while the same queue is popped: both happen and occupancy is unchanged.
- Tag format: `data_out[BITNUMBER-1]` = vc bit, `data_out[BITNUMBER-2]` = destination (queue index), `data_out[BITNUMBER-3:0]` = payload.
- Arbitration happens each edge with `pause` low.
  - If both queues are non-empty, grant the queue not granted last.
  - If only one queue is non-empty, grant it.
  - The granted queue pops one word.
  - The `last_grant` register updates only on an actual pop and resets to 1, so queue 0 wins the first tie.
- State machine, evaluated every edge:
  - IDLE -> ACTIVE when any queue is non-empty and `pause` is low.
  - IDLE -> PAUSED when `pause` is high and any queue is non-empty.
  - ACTIVE -> PAUSED when `pause` is high.
  - ACTIVE -> IDLE when both queues will be empty after this edge's pop and no push occurs.
  - PAUSED -> ACTIVE when `pause` is low and any queue is non-empty; PAUSED -> IDLE when `pause` is low and both queues are empty.
- `tx_count` increments on every cycle in which `push_out` is asserted.

## Timing
- Reset values: `data_out`=0, `push_out`=0, `full0`/`full1`=0, `empty0`/`empty1`=1, `wr_error0`/`wr_error1`=0, `state`=IDLE, `tx_count`=0, all pointers 0.
- Reset asserted mid-operation clears all queued words immediately, with no issue.
- `data_out` and `push_out` are registered.
  - A word popped at edge k is presented with `push_out`=1 during cycle k..k+1.
  - `push_out` is never high for two cycles with the same word.
- Latency from push to issue: a word pushed at edge k into an empty queue, with the other queue empty and `pause` low, is popped at edge k+1. `push_out` is high after edge k+1, so the latency is 2 cycles.
- `pause` is sampled at the edge. If `pause` is high at edge k, nothing is popped and `push_out` is 0 after edge k.
  - A word already issued after edge k-1 stays issued; the main FIFO almost-full threshold absorbs it.
- `data_out` holds its last value when `push_out`=0.
- Full and empty flags update on the same edge as the push or pop.
- Sustained throughput: one word per cycle while `pause` is low, alternating destinations when both queues are loaded.

## Test plan
- **Reset:** assert `reset` mid-stream with 3 words queued → all outputs at their reset values immediately; after release, `empty0`=`empty1`=1 and no `push_out`.
- **Single word:** push0 with payload 4'hA and vc=1 at edge 1 → `push_out`=1 after edge 2 with `data_out`=6'b10_1010; `tx_count`=1; `state` returns to IDLE.
- **Round-robin:** fill queue 0 with 0,1,2 and queue 1 with 5,6,7 on the same edges → issue order 0,5,1,6,2,7 (destination bit alternates 0,1,...); `tx_count`=6.
- **Overflow:** 5 consecutive push0 with `pause` held high → `full0`=1 after the 4th; the 5th push gives a `wr_error0` pulse of exactly 1 cycle; after `pause` drops, exactly 4 words are issued.
- **Pause mid-stream:** queue 4 words and raise `pause` after the 2nd issue → `state`=PAUSED and `push_out`=0 from the next cycle; on release the remaining 2 words are issued in order with no duplicate or loss.
- **Counter wrap:** issue 257 words → `tx_count` reads 1; simultaneous push and pop on a full queue drops the push and pulses `wr_error`.
